// File: rtl/alu_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_sched_pkg                                               |
// | Description : Shared types and constants for the round-robin ALU         |
// |               scheduler: FSM state enum, ALU opcode values, widths.      |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package alu_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   // Opcodes are forwarded to the ALU untouched; listed for requester use.
   localparam logic [2:0] OP_ADD     = 3'd0;
   localparam logic [2:0] OP_ADD_INC = 3'd1;
   localparam logic [2:0] OP_SUB_DEC = 3'd2;
   localparam logic [2:0] OP_SUB     = 3'd3;
   localparam logic [2:0] OP_PASS    = 3'd4;
   localparam logic [2:0] OP_INC     = 3'd5;
   localparam logic [2:0] OP_DEC     = 3'd6;
   localparam logic [2:0] OP_PASS7   = 3'd7;

   localparam int OP_W  = 3;
   localparam int CNT_W = 16;

   // Width of a requester index / round-robin pointer (at least one bit).
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rr_scheduler_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                  |
// | Description : Combinational round-robin picker. Grants the first active  |
// |               request found scanning ptr, ptr+1, ... modulo N.           |
// | Ports       : i_req    N-bit request vector                               |
// |               i_ptr    scan start index                                   |
// |               i_enable when low, no grant is produced                     |
// |               o_grant  one-hot (or zero) grant                            |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module rr_arbiter
   import alu_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]              i_req,
   input  logic [ptr_width(N)-1:0]   i_ptr,
   input  logic                      i_enable,
   output logic [N-1:0]              o_grant
);

   localparam int PW = ptr_width(N);

   // One extra bit so ptr+k (max 2N-2) never overflows before the wrap.
   function automatic logic [N-1:0] f_pick(input logic [N-1:0] req,
                                           input logic [PW-1:0] ptr);
      logic [N-1:0] g;
      logic         found;
      logic [PW:0]  idx;
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, ptr} + (PW+1)'(k);
         if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
         if (!found && req[idx[PW-1:0]]) begin
            g[idx[PW-1:0]] = 1'b1;
            found          = 1'b1;
         end
      end
      return g;
   endfunction

   assign o_grant = i_enable ? f_pick(i_req, i_ptr) : '0;

endmodule
`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_rr_scheduler                                            |
// | Description : Shares one fixed-latency ALU among NREQ requesters. Issues  |
// |               at most one op per cycle (round-robin), tracks in-flight   |
// |               ops by requester id and returns each result as a one-cycle |
// |               response strobe to its originator.                         |
// | Ports       : clk, arst          clock, synchronous active-high reset    |
// |               i_en, i_flush      enable / drain request                  |
// |               i_req_*, o_req_ready  requester valid/ready + operands      |
// |               o_alu_*, i_alu_*   ALU issue interface and result           |
// |               o_rsp_*            one-hot response strobe, result, carry   |
// |               o_busy, o_flush_done, o_op_count  status                    |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module alu_rr_scheduler
   import alu_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NBITS = 15,
   parameter int LAT   = 1
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic                       i_en,
   input  logic                       i_flush,
   input  logic [NREQ-1:0]            i_req_valid,
   output logic [NREQ-1:0]            o_req_ready,
   input  logic [NREQ*(NBITS+1)-1:0]  i_req_a,
   input  logic [NREQ*(NBITS+1)-1:0]  i_req_b,
   input  logic [NREQ*OP_W-1:0]       i_req_op,
   output logic [NBITS:0]             o_alu_a,
   output logic [NBITS:0]             o_alu_b,
   output logic [OP_W-1:0]            o_alu_op,
   output logic                       o_alu_valid,
   input  logic [NBITS+1:0]           i_alu_y,
   input  logic                       i_alu_co,
   output logic [NREQ-1:0]            o_rsp_valid,
   output logic [NBITS+1:0]           o_rsp_y,
   output logic                       o_rsp_co,
   output logic                       o_busy,
   output logic                       o_flush_done,
   output logic [CNT_W-1:0]           o_op_count
);

   localparam int PW = ptr_width(NREQ);
   localparam int DW = NBITS + 1;

   sched_state_t        r_state;
   logic                r_flush_done;
   logic [PW-1:0]       r_ptr;

   logic                r_alu_valid;
   logic [DW-1:0]       r_alu_a;
   logic [DW-1:0]       r_alu_b;
   logic [OP_W-1:0]     r_alu_op;
   logic [PW-1:0]       r_issue_id;

   logic [LAT-1:0]      r_tag_v;
   logic [PW-1:0]       r_tag_id [LAT];

   logic [NREQ-1:0]     r_rsp_valid;
   logic [NBITS+1:0]    r_rsp_y;
   logic                r_rsp_co;
   logic [CNT_W-1:0]    r_op_count;

   logic                w_grant_en;
   logic [NREQ-1:0]     w_grant;
   logic                w_xfer;
   logic [PW-1:0]       w_gid;
   logic [DW-1:0]       w_sel_a;
   logic [DW-1:0]       w_sel_b;
   logic [OP_W-1:0]     w_sel_op;
   logic                w_pipe_empty;
   logic                w_tag_last_v;
   logic [PW-1:0]       w_tag_last_id;

   // Grants are suppressed in the very cycle flush or ~en is observed.
   assign w_grant_en = (r_state == RUN) && i_en && !i_flush;

   rr_arbiter #(
      .N        (NREQ)
   ) u_arb (
      .i_req    (i_req_valid),
      .i_ptr    (r_ptr),
      .i_enable (w_grant_en),
      .o_grant  (w_grant)
   );

   assign o_req_ready = w_grant;
   // Grant is a subset of valid, so any grant bit is a transfer.
   assign w_xfer      = |w_grant;

   // Grant-driven operand mux and one-hot to index encode.
   always_comb begin
      w_gid    = '0;
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_sel_op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_gid    = PW'(i);
            w_sel_a  = i_req_a[i*DW +: DW];
            w_sel_b  = i_req_b[i*DW +: DW];
            w_sel_op = i_req_op[i*OP_W +: OP_W];
         end
      end
   end

   // The issue register plus LAT tag stages cover every op not yet returned.
   assign w_pipe_empty  = !r_alu_valid && !(|r_tag_v);
   assign w_tag_last_v  = r_tag_v[LAT-1];
   assign w_tag_last_id = r_tag_id[LAT-1];

   // Scheduler FSM with registered drain-complete pulse.
   always_ff @(posedge clk) begin
      if (arst) begin
         r_state      <= IDLE;
         r_flush_done <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_flush)   r_state <= DRAIN;
               else if (i_en) r_state <= RUN;
            end
            RUN: begin
               if (i_flush)    r_state <= DRAIN;
               else if (!i_en) r_state <= IDLE;
            end
            DRAIN: begin
               if (w_pipe_empty) begin
                  r_state      <= IDLE;
                  r_flush_done <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Issue stage and round-robin pointer.
   always_ff @(posedge clk) begin
      if (arst) begin
         r_ptr       <= '0;
         r_alu_valid <= 1'b0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_op    <= '0;
         r_issue_id  <= '0;
      end else begin
         r_alu_valid <= w_xfer;
         if (w_xfer) begin
            r_alu_a    <= w_sel_a;
            r_alu_b    <= w_sel_b;
            r_alu_op   <= w_sel_op;
            r_issue_id <= w_gid;
            r_ptr      <= (w_gid == PW'(NREQ-1)) ? '0 : w_gid + PW'(1);
         end
      end
   end

   // Tag pipeline: the last stage lines up with the ALU result being valid.
   always_ff @(posedge clk) begin
      if (arst) begin
         r_tag_v <= '0;
         for (int s = 0; s < LAT; s++) r_tag_id[s] <= '0;
      end else begin
         r_tag_v[0]  <= r_alu_valid;
         r_tag_id[0] <= r_issue_id;
         for (int s = 1; s < LAT; s++) begin
            r_tag_v[s]  <= r_tag_v[s-1];
            r_tag_id[s] <= r_tag_id[s-1];
         end
      end
   end

   // Response capture and completion counter.
   always_ff @(posedge clk) begin
      if (arst) begin
         r_rsp_valid <= '0;
         r_rsp_y     <= '0;
         r_rsp_co    <= 1'b0;
         r_op_count  <= '0;
      end else begin
         r_rsp_valid <= '0;
         if (w_tag_last_v) begin
            r_rsp_valid[w_tag_last_id] <= 1'b1;
            r_rsp_y                    <= i_alu_y;
            r_rsp_co                   <= i_alu_co;
            r_op_count                 <= r_op_count + CNT_W'(1);
         end
      end
   end

   assign o_alu_valid  = r_alu_valid;
   assign o_alu_a      = r_alu_a;
   assign o_alu_b      = r_alu_b;
   assign o_alu_op     = r_alu_op;
   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_y      = r_rsp_y;
   assign o_rsp_co     = r_rsp_co;
   assign o_flush_done = r_flush_done;
   assign o_op_count   = r_op_count;
   assign o_busy       = !w_pipe_empty || (|r_rsp_valid);

endmodule
`default_nettype wire
